// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ready channel between the fetch stage and imem.
// The fetch stage is the master; it holds imem_addr stable until imem_rdy.
interface fetch_stage_if;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic        imem_rdy;
  logic [15:0] imem_data;

  modport master (
    output imem_addr,
    output imem_req,
    input  imem_rdy,
    input  imem_data
  );

  modport slave (
    input  imem_addr,
    input  imem_req,
    output imem_rdy,
    output imem_data
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, imem handshake, IF/ID register,
// a one-entry skid for words returned under stall, and HALT detection.
module fetch_stage #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'hF,
  parameter logic [15:0] NOP_INSTR   = 16'h0000
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master imem,
  input  logic          i_stall,
  input  logic          i_redirect,
  input  logic [15:0]   i_redirect_pc,
  output logic [15:0]   o_pc,
  output logic [15:0]   o_if_id_instr,
  output logic [15:0]   o_if_id_pc,
  output logic [15:0]   o_if_id_pcInc,
  output logic          o_if_id_valid,
  output logic          o_halted
);

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_BUF,
    ST_HALT
  } state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_skid_instr;
  logic [15:0] r_skid_pc;
  logic [15:0] r_if_id_instr;
  logic [15:0] r_if_id_pc;
  logic [15:0] r_if_id_pcInc;
  logic        r_if_id_valid;
  logic        r_halted;

  logic        w_complete;
  logic [15:0] w_src_instr;
  logic [15:0] w_src_pc;
  logic [15:0] w_src_pc_inc;
  logic        w_src_is_halt;

  assign w_complete = (r_state == ST_FETCH) && imem.imem_rdy;

  // The word entering IF/ID comes from the skid in BUF, from imem otherwise.
  always_comb begin
    w_src_instr = imem.imem_data;
    w_src_pc    = r_pc;
    if (r_state == ST_BUF) begin
      w_src_instr = r_skid_instr;
      w_src_pc    = r_skid_pc;
    end
  end

  assign w_src_pc_inc  = w_src_pc + 16'd2;
  assign w_src_is_halt = (w_src_instr[15:12] == HALT_OPCODE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_FETCH;
      r_pc          <= RESET_PC;
      r_skid_instr  <= NOP_INSTR;
      r_skid_pc     <= '0;
      r_if_id_instr <= NOP_INSTR;
      r_if_id_pc    <= '0;
      r_if_id_pcInc <= '0;
      r_if_id_valid <= 1'b0;
      r_halted      <= 1'b0;
    end else if (i_redirect) begin
      r_state       <= ST_FETCH;
      r_pc          <= i_redirect_pc & 16'hFFFE;
      r_skid_instr  <= NOP_INSTR;
      r_skid_pc     <= '0;
      r_if_id_instr <= NOP_INSTR;
      r_if_id_valid <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (w_complete && i_stall) begin
            r_skid_instr <= imem.imem_data;
            r_skid_pc    <= r_pc;
            r_state      <= ST_BUF;
          end else if (w_complete) begin
            r_if_id_instr <= w_src_instr;
            r_if_id_pc    <= w_src_pc;
            r_if_id_pcInc <= w_src_pc_inc;
            r_if_id_valid <= 1'b1;
            if (w_src_is_halt) begin
              r_state  <= ST_HALT;
              r_halted <= 1'b1;
            end else begin
              r_pc <= w_src_pc_inc;
            end
          end else if (!i_stall) begin
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
          end
        end
        ST_BUF: begin
          if (!i_stall) begin
            r_if_id_instr <= w_src_instr;
            r_if_id_pc    <= w_src_pc;
            r_if_id_pcInc <= w_src_pc_inc;
            r_if_id_valid <= 1'b1;
            r_skid_instr  <= NOP_INSTR;
            if (w_src_is_halt) begin
              r_state  <= ST_HALT;
              r_halted <= 1'b1;
            end else begin
              r_pc    <= w_src_pc_inc;
              r_state <= ST_FETCH;
            end
          end
        end
        ST_HALT: begin
          r_halted <= 1'b1;
        end
        default: begin
          r_state <= ST_FETCH;
        end
      endcase
    end
  end

  assign imem.imem_req  = (r_state == ST_FETCH);
  assign imem.imem_addr = r_pc;

  assign o_pc          = r_pc;
  assign o_if_id_instr = r_if_id_instr;
  assign o_if_id_pc    = r_if_id_pc;
  assign o_if_id_pcInc = r_if_id_pcInc;
  assign o_if_id_valid = r_if_id_valid;
  assign o_halted      = r_halted;

endmodule
